word_tx_queue: RTL
==================

# word_tx_queue

Buffers 16-bit words produced by the core and feeds them one at a time to the UART transceiver's `data_send`/`data_send_valid` input. The transceiver has no ready/busy output, and it reads the low byte of `data_send` late in the transfer. This block therefore paces launches by a fixed word period and holds `data_send` stable for the whole transfer. It sits between the core and the transceiver.

## Interface
- `DEPTH`, 8: queue depth in words; power of two, ≥2.
- `CLKS_PER_BIT`, 434: UART bit period in clocks; must match the transceiver.
- `WORD_CLKS`, 21*CLKS_PER_BIT: cycles between consecutive launches; ≥3. Covers 2 frames × 10 bits plus one bit of margin.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `wr_data`  in  16  word from the core.
- `wr_valid`  in  1  write request; accepted in a cycle where `wr_valid & wr_ready`.
- `wr_ready`  out  1  high when the queue is not full.
- `data_send`  out  16  word to the transceiver; registered.
- `data_send_valid`  out  1  one-cycle launch pulse to the transceiver; registered.
- `level`  out  $clog2(DEPTH)+1  number of words queued, not counting the word in flight.
- `busy`  out  1  high when the FSM is not in IDLE or `level != 0`.
- `overflow`  out  1  sticky dropped-write flag (only with `WORD_TX_QUEUE_OVF_EN`).
- `drop_count`  out  8  dropped writes, saturating at 255 (only with `WORD_TX_QUEUE_OVF_EN`).

## Operation
- The FIFO stores words in order; `wr_ready = !full`, computed from the current level only.
- A write while full is not accepted, even if a pop happens in the same cycle.
- FSM states:
  - IDLE: if the FIFO is not empty, pop the head into `data_send`, set `data_send_valid=1`, go to LAUNCH.
  - LAUNCH: clear `data_send_valid`, load the holdoff counter, go to HOLD.
  - HOLD: decrement the counter. When it expires, go to IDLE so that the next launch falls exactly `WORD_CLKS` cycles after the previous pulse.
- `data_send` changes only on a launch edge. Between launches it holds the last word.
- A simultaneous write and pop leaves `level` unchanged. Write data is never visible to the pop in the same cycle.
- Reset mid-operation:
  - All state clears immediately, including queued words.
  - The transceiver must be reset by the same event, with `rstb` driven as `!rst`.
  - No partial word is re-launched.
- Arithmetic:
  - The counter is `$clog2(WORD_CLKS)` bits wide, unsigned.
  - `level` is wide enough to hold `DEPTH`.
  - FIFO pointers wrap modulo `DEPTH`, with one extra bit for full/empty.

## Timing
- Reset values:
  - `data_send=16'h0`, `data_send_valid=0`, `level=0`, `busy=0`.
  - `wr_ready=1`, `overflow=0`, `drop_count=0`.
  - FSM in IDLE.
- Latency: a word written in cycle c into an empty, idle queue gives `data_send_valid=1` in cycle c+2.
- Throughput: one word per `WORD_CLKS` cycles. Pulse-to-pulse spacing is exactly `WORD_CLKS` while words are queued.
- `data_send_valid` is high for exactly one cycle per word.
- The transceiver samples on the falling edge, so the registered outputs are stable half a cycle before they are sampled.
- `wr_ready` and `level` update on the edge after the write or pop.

## Configuration
- Macro: `WORD_TX_QUEUE_OVF_EN`.
- Defined:
  - `overflow` and `drop_count` ports exist.
  - Each cycle with `wr_valid & !wr_ready` sets `overflow` and increments `drop_count`, saturating at 255.
  - Both clear only on `rst`.
- Undefined: ports and logic are absent; writes while full are silently ignored.

## Structure
- Package `word_tx_queue_pkg`:
  - `tx_q_state_t` enum `{IDLE, LAUNCH, HOLD}`.
  - `localparam` UART frame length of 10 bits and default word-clock factor of 21.
- Sub-module `word_fifo`: synchronous `DEPTH`×16 FIFO with async active-high reset, push/pop, full/empty and level outputs.
- The top level holds the FSM, holdoff counter, output registers and overflow logic.

## Test plan
- Reset: assert `rst` → all outputs at reset values; `wr_ready=1`.
- Single word: `CLKS_PER_BIT=4` (`WORD_CLKS=84`), write `16'hA55A` in cycle c.
  - `data_send_valid` pulses in cycle c+2 with `data_send=16'hA55A`.
  - `data_send` is still `16'hA55A` at c+80.
- Burst: write `16'h0001`, `16'h0002`, `16'h0003` back-to-back from cycle c.
  - Pulses in cycles c+2, c+86 and c+170 carry the words in that order.
  - `level` peaks at 2 and ends at 0.
- Full/overflow: `DEPTH=4`, `WORD_TX_QUEUE_OVF_EN` defined. During HOLD, write 5 words.
  - After the 4th write, `wr_ready=0`.
  - The 5th write is dropped: `overflow=1`, `drop_count=1`.
  - The dropped word never appears on `data_send`.
- Simultaneous push/pop: with `level=1` in IDLE, write during the pop cycle.
  - `level` stays 1.
  - The next launch carries the new word.
- Reset during HOLD with 3 words queued: pulse `rst`.
  - `level=0`, `data_send=0`, FSM in IDLE.
  - A new write in cycle c launches in cycle c+2.

Source files
------------

// File: rtl/word_tx_queue_pkg.sv
// Shared types and constants for the paced UART word transmit queue.
package word_tx_queue_pkg;

  localparam int unsigned UART_FRAME_BITS = 10;
  // Two byte frames per word plus one bit period of margin.
  localparam int unsigned WORD_CLK_FACTOR = 2 * UART_FRAME_BITS + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    HOLD   = 2'd2
  } tx_q_state_t;

endpackage

// File: rtl/word_fifo.sv
// DEPTH x 16 synchronous FIFO; pointers carry one extra bit to separate full from empty.
module word_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [15:0]              push_data,
  input  logic                     push,
  input  logic                     pop,
  output logic [15:0]              pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [15:0]   mem [DEPTH];
  logic          do_push;
  logic          do_pop;

  assign level    = wr_ptr - rd_ptr;
  assign full     = (level == PW'(DEPTH));
  assign empty    = (level == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage needs no reset: the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/word_tx_queue.sv
// Queues core words and launches them to the UART transceiver at a fixed word period.
// Optional overflow reporting enabled by defining WORD_TX_QUEUE_OVF_EN.
module word_tx_queue
  import word_tx_queue_pkg::*;
#(
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned WORD_CLKS    = WORD_CLK_FACTOR * CLKS_PER_BIT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [15:0]            wr_data,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  output logic [15:0]            data_send,
  output logic                   data_send_valid,
  output logic [$clog2(DEPTH):0] level,
  output logic                   busy
`ifdef WORD_TX_QUEUE_OVF_EN
  ,
  output logic                   overflow,
  output logic [7:0]             drop_count
`endif
);

  localparam int unsigned CNT_W = $clog2(WORD_CLKS);

  tx_q_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      data_send_d;
  logic             data_send_valid_d;
  logic             pop_c;
  logic             full;
  logic             empty;
  logic [15:0]      head;

  word_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_data (wr_data),
    .push      (wr_valid),
    .pop       (pop_c),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

  assign wr_ready = ~full;
  assign busy     = (state_q != IDLE) || (level != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      data_send       <= 16'h0;
      data_send_valid <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      data_send       <= data_send_d;
      data_send_valid <= data_send_valid_d;
    end
  end

  // HOLD lasts WORD_CLKS-2 cycles so IDLE pops exactly one word period after the last pulse.
  always_comb begin
    state_d           = state_q;
    cnt_d             = cnt_q;
    data_send_d       = data_send;
    data_send_valid_d = 1'b0;
    pop_c             = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop_c             = 1'b1;
          data_send_d       = head;
          data_send_valid_d = 1'b1;
          state_d           = LAUNCH;
        end
      end
      LAUNCH: begin
        cnt_d   = CNT_W'(WORD_CLKS - 3);
        state_d = HOLD;
      end
      HOLD: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef WORD_TX_QUEUE_OVF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow   <= 1'b0;
      drop_count <= 8'd0;
    end else if (wr_valid && full) begin
      overflow <= 1'b1;
      if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
    end
  end
`endif

endmodule
